// File: rtl/camera_gen_pkg.sv
// camera_gen_pkg: shared types and constants for the camera pattern generator.
package camera_gen_pkg;
   typedef enum logic [2:0] {S_IDLE, S_VPRE, S_LINE, S_HBLANK, S_VPOST, S_DONE} state_t;
   typedef enum logic [1:0] {MODE_CONST, MODE_HRAMP, MODE_VRAMP, MODE_LFSR} mode_t;
   localparam int LFSR_W = 16;
   // x^16+x^14+x^13+x^11+1 taps on bits 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cam_lfsr16.sv
// cam_lfsr16: 16-bit Fibonacci LFSR, shifts left with feedback into bit 0.
module cam_lfsr16
   import camera_gen_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else if (load) q <= seed;
      else if (advance) q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
   end
endmodule

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen: emits one frame_valid/line_valid/pixel_data frame per start trigger.
module camera_pattern_gen
   import camera_gen_pkg::*;
#(
   parameter int          PIX_W  = 10,
   parameter int          COLS   = 1280,
   parameter int          ROWS   = 800,
   parameter int          HBLANK = 32,
   parameter int          VPRE   = 16,
   parameter int          VPOST  = 16,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] const_val,
   output logic             frame_valid,
   output logic             line_valid,
   output logic [PIX_W-1:0] pixel_data,
   output logic             busy,
   output logic             done,
   output logic [15:0]      frame_count,
   output logic             overrun
);
   localparam int BMAX = (HBLANK > VPRE ? HBLANK : VPRE) > VPOST ? (HBLANK > VPRE ? HBLANK : VPRE) : VPOST;
   localparam int CW = cnt_w(COLS);
   localparam int RW = cnt_w(ROWS);
   localparam int BW = cnt_w(BMAX);
   state_t            state, state_n;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [BW-1:0]     cnt;
   mode_t             mode_r;
   logic [PIX_W-1:0]  cval_r;
   logic [15:0]       lfsr_q;
   logic              accept;
   assign accept = state == S_IDLE && start;
   cam_lfsr16 u_lfsr (
      .clk(clk), .reset(reset), .load(accept), .seed(SEED),
      .advance(state == S_LINE), .q(lfsr_q)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         cnt         <= '0;
         mode_r      <= MODE_CONST;
         cval_r      <= '0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= state_n == state ? cnt + 1'b1 : '0;
         col         <= state == S_LINE && state_n == S_LINE ? col + 1'b1 : '0;
         row         <= accept ? '0 : state == S_HBLANK && state_n == S_LINE ? row + 1'b1 : row;
         mode_r      <= accept ? mode_t'(mode) : mode_r;
         cval_r      <= accept ? const_val : cval_r;
         frame_count <= frame_count + 16'(state_n == S_DONE && state == S_VPOST);
         overrun     <= overrun | (start && state != S_IDLE);
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   state_n = start ? S_VPRE : S_IDLE;
         S_VPRE:   state_n = cnt == BW'(VPRE - 1) ? S_LINE : S_VPRE;
         S_LINE:   state_n = col != CW'(COLS - 1) ? S_LINE : row == RW'(ROWS - 1) ? S_VPOST : S_HBLANK;
         S_HBLANK: state_n = cnt == BW'(HBLANK - 1) ? S_LINE : S_HBLANK;
         S_VPOST:  state_n = cnt == BW'(VPOST - 1) ? S_DONE : S_VPOST;
         default:  state_n = S_IDLE;
      endcase
   end
   always_comb begin
      frame_valid = state inside {S_VPRE, S_LINE, S_HBLANK, S_VPOST};
      line_valid  = state == S_LINE;
      busy        = state != S_IDLE;
      done        = state == S_DONE;
      pixel_data  = !line_valid          ? '0 :
                    mode_r == MODE_CONST ? cval_r :
                    mode_r == MODE_HRAMP ? PIX_W'(col) :
                    mode_r == MODE_VRAMP ? PIX_W'(row) : PIX_W'(lfsr_q);
   end
endmodule

// File: tb/tb_camera_pattern_gen.sv
// tb_camera_pattern_gen: directed frames on a 4x3 geometry against hand-derived expectations.
module tb_camera_pattern_gen;
   localparam int PW = 10;
   logic          clk = 1'b0;
   logic          reset, start;
   logic [1:0]    mode;
   logic [PW-1:0] const_val;
   logic          frame_valid, line_valid, busy, done, overrun;
   logic [PW-1:0] pixel_data;
   logic [15:0]   frame_count;
   int            n_cmp = 0, n_bad = 0;
   logic [PW-1:0] pix [0:63];
   logic [PW-1:0] lfsr_seq [0:11];
   logic [PW-1:0] prev [0:11];
   int            npix, fv_cyc, first_lv, fc_at_done, done_seen, idle_bad;

   camera_pattern_gen #(
      .PIX_W(PW), .COLS(4), .ROWS(3), .HBLANK(2), .VPRE(1), .VPOST(1), .SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .const_val(const_val),
      .frame_valid(frame_valid), .line_valid(line_valid), .pixel_data(pixel_data),
      .busy(busy), .done(done), .frame_count(frame_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // kind 1 injects a second start at sample inj, kind 2 pulses reset there
   task automatic run_frame(input logic [1:0] m, input logic [PW-1:0] cv, input int inj, input int kind);
      @(negedge clk);
      start = 1'b1; mode = m; const_val = cv;
      @(negedge clk);
      start = 1'b0; mode = ~m; const_val = ~cv;
      npix = 0; fv_cyc = 0; first_lv = -1; done_seen = 0; idle_bad = 0;
      check("fv_after_start", frame_valid, 1);
      check("busy_after_start", busy, 1);
      for (int i = 0; i < 200; i++) begin
         if (i > 0) @(negedge clk);
         if (kind == 2 && i == inj + 1) begin
            check("rst_fv", frame_valid, 0);
            check("rst_lv", line_valid, 0);
            check("rst_pix", pixel_data, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_fc", frame_count, 0);
            check("rst_ovr", overrun, 0);
            reset = 1'b0;
            return;
         end
         if (i == inj + 1) start = 1'b0;
         if (frame_valid) fv_cyc++;
         if (line_valid) begin
            if (first_lv < 0) first_lv = i;
            if (npix < 64) pix[npix] = pixel_data;
            npix++;
         end else if (pixel_data != 0) idle_bad++;
         if (done) begin
            done_seen = 1;
            fc_at_done = frame_count;
            check("busy_in_done", busy, 1);
            check("fv_in_done", frame_valid, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
            break;
         end
         if (i == inj) begin
            if (kind == 1) begin start = 1'b1; mode = 2'd0; end
            else if (kind == 2) reset = 1'b1;
         end
      end
      if (done_seen == 0) check("done_timeout", 0, 1);
   endtask

   task automatic verify_frame(input logic [1:0] m, input logic [PW-1:0] cv, input int exp_fc);
      logic [PW-1:0] e;
      check($sformatf("m%0d_fv_cycles", m), fv_cyc, 18);
      check($sformatf("m%0d_npix", m), npix, 12);
      check($sformatf("m%0d_first_lv", m), first_lv, 1);
      check($sformatf("m%0d_idle_pix", m), idle_bad, 0);
      check($sformatf("m%0d_fc", m), fc_at_done, exp_fc);
      for (int k = 0; k < 12; k++) begin
         e = m == 2'd0 ? cv : m == 2'd1 ? PW'(k % 4) : m == 2'd2 ? PW'(k / 4) : lfsr_seq[k];
         check($sformatf("m%0d_pix%0d", m, k), pix[k], e);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] q;
      q = 16'hACE1;
      for (int k = 0; k < 12; k++) begin
         lfsr_seq[k] = q[PW-1:0];
         q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
      end
      reset = 1'b1; start = 1'b0; mode = 2'd0; const_val = '0;
      repeat (3) @(negedge clk);
      check("reset_fv", frame_valid, 0);
      check("reset_lv", line_valid, 0);
      check("reset_pix", pixel_data, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_fc", frame_count, 0);
      check("reset_ovr", overrun, 0);
      reset = 1'b0;

      run_frame(2'd1, '0, -5, 0);
      verify_frame(2'd1, '0, 1);
      run_frame(2'd2, '0, -5, 0);
      verify_frame(2'd2, '0, 2);
      run_frame(2'd0, 10'h155, -5, 0);
      verify_frame(2'd0, 10'h155, 3);
      run_frame(2'd3, '0, -5, 0);
      verify_frame(2'd3, '0, 4);
      check("lfsr_pix0", pix[0], 10'h0E1);
      check("lfsr_pix1", pix[1], 10'h1C3);
      for (int k = 0; k < 12; k++) prev[k] = pix[k];
      run_frame(2'd3, '0, -5, 0);
      verify_frame(2'd3, '0, 5);
      for (int k = 0; k < 12; k++) check($sformatf("lfsr_repeat%0d", k), pix[k], prev[k]);
      check("no_overrun_yet", overrun, 0);

      run_frame(2'd1, '0, 2, 1);
      verify_frame(2'd1, '0, 6);
      check("overrun_set", overrun, 1);
      check("fc_after_overrun", frame_count, 6);

      run_frame(2'd2, '0, 8, 2);
      run_frame(2'd1, '0, -5, 0);
      verify_frame(2'd1, '0, 1);
      check("ovr_after_reset_frame", overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
